video_in_capture: RTL and testbench
===================================

Name: video_in_capture

Overview:
- Front-end of the edge detection core: samples the raw parallel video bus (I_PCLK, I_VSYNC, I_HSYNC, I_DE, I_PIX_DATA) in the core clock domain.
- Tracks frame and line position and converts each RGB888 pixel to 8-bit luma.
- Emits a single-cycle-valid pixel stream with column/row and frame/line markers for the downstream line buffers and Sobel stage.

Parameters:
SYNC_STAGES, 2, synchronizer depth applied to every video input, including pixel data
COL_W, 11, column counter width
ROW_W, 10, row counter width

Ports:
I_CORE_CLK  in  1  core clock, the only clock; rising edge
I_RST_N  in  1  reset, asynchronous assert, active-low
I_PCLK  in  1  pixel clock from pad, treated as data
I_VSYNC  in  1  vertical sync, active-high
I_HSYNC  in  1  horizontal sync, active-high, status only
I_DE  in  1  data enable, active-high
I_PIX_DATA  in  24  RGB888 pixel: R=[23:16], G=[15:8], B=[7:0]
O_GRAY  out  8  luma of emitted pixel
O_VALID  out  1  one-cycle pixel strobe
O_SOF  out  1  with O_VALID: first pixel of frame
O_EOL  out  1  with O_VALID: last pixel of line
O_EOF  out  1  one-cycle pulse, frame complete, no O_VALID
O_COL  out  COL_W  column of emitted pixel
O_ROW  out  ROW_W  row of emitted pixel
O_LOCKED  out  1  FSM has seen a frame start
O_ERR  out  1  one-cycle pulse: VSYNC rose mid-line

Behaviour:
- Reset: all outputs 0 while I_RST_N=0. FSM goes to UNLOCKED. Counters, hold register and pipeline are cleared.
- Input sampling:
  - All video inputs pass through SYNC_STAGES flops.
  - Strobe = synced PCLK rising edge (0 then 1 on consecutive cycles); it is one core cycle wide.
  - On a strobe, the synced DE, VSYNC and data are captured.
  - Requirement: I_CORE_CLK >= 4x I_PCLK, and data/syncs are stable around the PCLK rising edge. Behaviour outside this is undefined.
- VSYNC rise = strobe with VSYNC=1 where the previous strobe had VSYNC=0. DE rise and DE fall are defined the same way on strobes.
- FSM, evaluated only on strobes:
  - UNLOCKED: DE ignored. On VSYNC rise -> VBLANK.
  - VBLANK: on DE=1 -> ACTIVE. Row=0, col=0, mark SOF pending, load the hold register.
  - ACTIVE, DE=1: emit the held pixel, load the new pixel, col++.
  - ACTIVE, DE=0: emit the held pixel with EOL=1 -> HBLANK.
  - ACTIVE, VSYNC rise: discard the held pixel, pulse O_ERR -> VBLANK. No EOF.
  - HBLANK, DE rise: row++, col=0, load the hold register -> ACTIVE.
  - HBLANK, VSYNC rise: pulse O_EOF -> VBLANK.
  - O_LOCKED = (state != UNLOCKED).
- One-pixel hold: a pixel is emitted only when the next strobe arrives, so that EOL can be flagged on the last pixel itself.
- Counters saturate at all-ones; they never wrap.
- Luma:
  - Y = (77*R + 150*G + 29*B) >> 8, using a 16-bit unsigned sum (max 65280). Result is always <= 255; no rounding.
  - Pipeline: stage 1 registers the three products, stage 2 registers the sum >> 8.
  - Col, row, SOF and EOL are delayed to match.
- Latency: O_VALID is asserted exactly 2 core cycles after the emitting strobe. O_EOF and O_ERR are also 2 cycles after their strobe.
- O_SOF is set only on the first emitted pixel after VBLANK.
- HSYNC is synchronized but does not affect the FSM; DE alone defines lines.
- Async reset mid-frame: returns to UNLOCKED. No output until the next VSYNC rise and DE.

Decomposition:
- Shared package: FSM state enum (UNLOCKED, VBLANK, ACTIVE, HBLANK), luma coefficients (77, 150, 29) and shift (8), RGB field offsets.
- Sub-module rgb_to_luma: the 2-stage multiply-add pipeline with a sideband delay, for reuse elsewhere.
- A generic sync_ff (SYNC_STAGES-deep) is instantiated per input.

Test Plan:
- Reset: hold I_RST_N=0 while toggling all inputs -> all outputs 0, O_LOCKED=0. Release -> still 0 until a VSYNC rise.
- Frame of 4x3 pixels, CORE=4x PCLK, VSYNC, then 3 lines of DE=4 PCLKs, then VSYNC:
  - exactly 12 O_VALID pulses;
  - O_SOF on pulse 1; O_EOL on pulses 4, 8, 12;
  - O_COL 0..3, O_ROW 0..2;
  - one O_EOF.
- Luma values: 0xFFFFFF -> 255; 0xFF0000 -> 76; 0x00FF00 -> 149; 0x0000FF -> 28; 0x000000 -> 0. Each appears 2 core cycles after its emitting strobe.
- DE bursts before any VSYNC -> no O_VALID, O_LOCKED=0. After the VSYNC rise -> O_LOCKED=1.
- VSYNC rise on the 3rd pixel of a line -> O_ERR pulse, the held pixel is never emitted, no O_EOF. The next DE starts row 0 with O_SOF.
- I_RST_N pulsed low mid-line -> outputs 0 asynchronously. After release, no output until a new VSYNC rise; the next frame starts at row 0, col 0.

Source files
------------

// File: rtl/video_in_capture_pkg.sv
// Shared types and constants for the video capture front-end.
// Holds the FSM state encoding, the luma coefficients and the RGB888 field layout.
package video_in_capture_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_VBLANK   = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_HBLANK   = 2'd3
  } cap_state_t;

  localparam int unsigned LUMA_COEF_R = 77;
  localparam int unsigned LUMA_COEF_G = 150;
  localparam int unsigned LUMA_COEF_B = 29;
  localparam int unsigned LUMA_SHIFT  = 8;

  localparam int unsigned RGB_R_LSB = 16;
  localparam int unsigned RGB_G_LSB = 8;
  localparam int unsigned RGB_B_LSB = 0;

  function automatic logic [7:0] rgb_field(input logic [23:0] rgb, input int unsigned lsb);
    return rgb[lsb +: 8];
  endfunction

endpackage

// File: rtl/rgb_to_luma.sv
// Two-stage RGB888 to 8-bit luma pipeline with a matching sideband delay.
// Latency 2 cycles, no backpressure; sideband reads zero whenever out_vld is low.
module rgb_to_luma
  import video_in_capture_pkg::*;
#(
  parameter int SIDE_W = 1
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [23:0]       in_rgb,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_vld,
  output logic [7:0]        out_y,
  output logic [SIDE_W-1:0] out_side
);

  logic [15:0]       prod_r, prod_g, prod_b;
  logic              vld1;
  logic [SIDE_W-1:0] side1;
  logic [15:0]       sum;

  // Coefficients add up to 256, so the 16-bit sum tops out at 65280 and never overflows.
  assign sum = prod_r + prod_g + prod_b;

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r   <= '0;
      prod_g   <= '0;
      prod_b   <= '0;
      vld1     <= 1'b0;
      side1    <= '0;
      out_vld  <= 1'b0;
      out_y    <= '0;
      out_side <= '0;
    end else begin
      prod_r   <= 16'(LUMA_COEF_R) * {8'd0, rgb_field(in_rgb, RGB_R_LSB)};
      prod_g   <= 16'(LUMA_COEF_G) * {8'd0, rgb_field(in_rgb, RGB_G_LSB)};
      prod_b   <= 16'(LUMA_COEF_B) * {8'd0, rgb_field(in_rgb, RGB_B_LSB)};
      vld1     <= in_vld;
      side1    <= in_vld ? in_side : '0;
      out_vld  <= vld1;
      out_y    <= 8'(sum >> LUMA_SHIFT);
      out_side <= side1;
    end
  end

endmodule

// File: rtl/sync_ff.sv
// Generic multi-stage flop chain bringing an asynchronous bus into core_clk.
// Latency STAGES cycles, no backpressure.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             core_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/video_in_capture.sv
// Samples the raw video bus in the core clock, tracks frame/line position and emits gray pixels.
// Pixel, EOF and ERR outputs appear 2 cycles after the PCLK strobe that triggers them; no backpressure.
module video_in_capture
  import video_in_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COL_W       = 11,
  parameter int ROW_W       = 10
) (
  input  logic             I_CORE_CLK,
  input  logic             I_RST_N,
  input  logic             I_PCLK,
  input  logic             I_VSYNC,
  input  logic             I_HSYNC,
  input  logic             I_DE,
  input  logic [23:0]      I_PIX_DATA,
  output logic [7:0]       O_GRAY,
  output logic             O_VALID,
  output logic             O_SOF,
  output logic             O_EOL,
  output logic             O_EOF,
  output logic [COL_W-1:0] O_COL,
  output logic [ROW_W-1:0] O_ROW,
  output logic             O_LOCKED,
  output logic             O_ERR
);

  localparam int SIDE_W = 2 + COL_W + ROW_W;

  logic        pclk_s, vsync_s, hsync_s, de_s;
  logic [23:0] pix_s;
  logic        hsync_unused;

  sync_ff #(.WIDTH(1),  .STAGES(SYNC_STAGES)) u_sync_pclk  (.core_clk(I_CORE_CLK), .rst_n(I_RST_N), .d(I_PCLK),     .q(pclk_s));
  sync_ff #(.WIDTH(1),  .STAGES(SYNC_STAGES)) u_sync_vsync (.core_clk(I_CORE_CLK), .rst_n(I_RST_N), .d(I_VSYNC),    .q(vsync_s));
  sync_ff #(.WIDTH(1),  .STAGES(SYNC_STAGES)) u_sync_hsync (.core_clk(I_CORE_CLK), .rst_n(I_RST_N), .d(I_HSYNC),    .q(hsync_s));
  sync_ff #(.WIDTH(1),  .STAGES(SYNC_STAGES)) u_sync_de    (.core_clk(I_CORE_CLK), .rst_n(I_RST_N), .d(I_DE),       .q(de_s));
  sync_ff #(.WIDTH(24), .STAGES(SYNC_STAGES)) u_sync_pix   (.core_clk(I_CORE_CLK), .rst_n(I_RST_N), .d(I_PIX_DATA), .q(pix_s));

  // Line boundaries come from DE alone; HSYNC is carried through for status only.
  assign hsync_unused = hsync_s;

  logic pclk_d, vsync_prev, de_prev;
  logic strobe, vsync_rise, de_rise;

  assign strobe     = pclk_s & ~pclk_d;
  assign vsync_rise = strobe & vsync_s & ~vsync_prev;
  assign de_rise    = strobe & de_s & ~de_prev;

  cap_state_t       state_q, state_nxt;
  logic [COL_W-1:0] col_q, col_nxt;
  logic [ROW_W-1:0] row_q, row_nxt;
  logic             sof_pend_q, sof_pend_nxt;
  logic [23:0]      hold_q, hold_nxt;
  logic             emit, emit_eol, eof_now, err_now;
  logic [1:0]       eof_pipe, err_pipe;

  always_ff @(posedge I_CORE_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      pclk_d     <= 1'b0;
      vsync_prev <= 1'b0;
      de_prev    <= 1'b0;
      state_q    <= ST_UNLOCKED;
      col_q      <= '0;
      row_q      <= '0;
      sof_pend_q <= 1'b0;
      hold_q     <= '0;
      eof_pipe   <= '0;
      err_pipe   <= '0;
    end else begin
      pclk_d <= pclk_s;
      if (strobe) begin
        vsync_prev <= vsync_s;
        de_prev    <= de_s;
      end
      state_q    <= state_nxt;
      col_q      <= col_nxt;
      row_q      <= row_nxt;
      sof_pend_q <= sof_pend_nxt;
      hold_q     <= hold_nxt;
      eof_pipe   <= {eof_pipe[0], eof_now};
      err_pipe   <= {err_pipe[0], err_now};
    end
  end

  // A pixel sits in hold_q until the next strobe tells us whether it ends the line.
  always_comb begin
    state_nxt    = state_q;
    col_nxt      = col_q;
    row_nxt      = row_q;
    sof_pend_nxt = sof_pend_q;
    hold_nxt     = hold_q;
    emit         = 1'b0;
    emit_eol     = 1'b0;
    eof_now      = 1'b0;
    err_now      = 1'b0;
    if (strobe) begin
      unique case (state_q)
        ST_UNLOCKED: begin
          if (vsync_rise) state_nxt = ST_VBLANK;
        end
        ST_VBLANK: begin
          if (de_s) begin
            state_nxt    = ST_ACTIVE;
            row_nxt      = '0;
            col_nxt      = '0;
            sof_pend_nxt = 1'b1;
            hold_nxt     = pix_s;
          end
        end
        ST_ACTIVE: begin
          if (vsync_rise) begin
            err_now   = 1'b1;
            state_nxt = ST_VBLANK;
          end else if (de_s) begin
            emit         = 1'b1;
            hold_nxt     = pix_s;
            col_nxt      = (&col_q) ? col_q : col_q + 1'b1;
            sof_pend_nxt = 1'b0;
          end else begin
            emit         = 1'b1;
            emit_eol     = 1'b1;
            sof_pend_nxt = 1'b0;
            state_nxt    = ST_HBLANK;
          end
        end
        ST_HBLANK: begin
          if (vsync_rise) begin
            eof_now   = 1'b1;
            state_nxt = ST_VBLANK;
          end else if (de_rise) begin
            row_nxt   = (&row_q) ? row_q : row_q + 1'b1;
            col_nxt   = '0;
            hold_nxt  = pix_s;
            state_nxt = ST_ACTIVE;
          end
        end
        default: state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  rgb_to_luma #(.SIDE_W(SIDE_W)) u_luma (
    .core_clk (I_CORE_CLK),
    .rst_n    (I_RST_N),
    .in_vld   (emit),
    .in_rgb   (hold_q),
    .in_side  ({sof_pend_q, emit_eol, col_q, row_q}),
    .out_vld  (O_VALID),
    .out_y    (O_GRAY),
    .out_side ({O_SOF, O_EOL, O_COL, O_ROW})
  );

  assign O_EOF    = eof_pipe[1];
  assign O_ERR    = err_pipe[1];
  assign O_LOCKED = (state_q != ST_UNLOCKED);

endmodule

// File: tb/tb_video_in_capture.sv
// Randomized bench for video_in_capture: frame-level reference model and event scoreboard.
module tb_video_in_capture;

  localparam int SYNC_STAGES = 2;
  localparam int COL_W       = 11;
  localparam int ROW_W       = 10;
  localparam int LAT         = SYNC_STAGES + 2;
  localparam int CMAX        = (1 << COL_W) - 1;
  localparam int K_PIX = 0, K_EOF = 1, K_ERR = 2;

  logic             core_clk = 1'b0;
  logic             rst_n, pclk, vsync, hsync, de;
  logic [23:0]      pix;
  logic [7:0]       gray;
  logic             valid, sof, eol, eof, locked, err;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [34:0]      out_all;

  video_in_capture #(.SYNC_STAGES(SYNC_STAGES), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .I_CORE_CLK(core_clk), .I_RST_N(rst_n), .I_PCLK(pclk), .I_VSYNC(vsync),
    .I_HSYNC(hsync), .I_DE(de), .I_PIX_DATA(pix),
    .O_GRAY(gray), .O_VALID(valid), .O_SOF(sof), .O_EOL(eol), .O_EOF(eof),
    .O_COL(col), .O_ROW(row), .O_LOCKED(locked), .O_ERR(err)
  );

  assign out_all = {gray, valid, sof, eol, eof, col, row, locked, err};

  always #5 core_clk = ~core_clk;

  int cyc = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  int n_valid = 0, n_eof = 0, n_errp = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int kind; int cyc; int gray; int col; int row; bit sof; bit eol;
  } exp_t;
  exp_t q[$];

  logic [23:0] pat_rgb [5] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000};
  int          pat_y   [5] = '{255, 76, 149, 28, 0};
  int          pat_idx = 0;

  function automatic int luma_ref(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
  endfunction

  task automatic push_pix(input int rc, input int y, input int c, input int r, input bit s, input bit e);
    exp_t x;
    x.kind = K_PIX; x.cyc = rc + LAT; x.gray = y;
    x.col = (c > CMAX) ? CMAX : c; x.row = r; x.sof = s; x.eol = e;
    q.push_back(x);
  endtask

  task automatic push_ev(input int kind, input int rc);
    exp_t x;
    x.kind = kind; x.cyc = rc + LAT; x.gray = 0; x.col = 0; x.row = 0; x.sof = 0; x.eol = 0;
    q.push_back(x);
  endtask

  // One PCLK period (4 core cycles): inputs change with the falling edge, rc = cycle of the rising edge.
  task automatic tick(input bit vs, input bit d_en, input logic [23:0] d, output int rc);
    @(posedge core_clk); #1;
    pclk = 1'b0; vsync = vs; de = d_en; pix = d; hsync = 1'($urandom);
    @(posedge core_clk); #1;
    @(posedge core_clk); #1;
    pclk = 1'b1; rc = cyc;
    @(posedge core_clk);
  endtask

  task automatic blank();
    int rc;
    tick(1'b0, 1'b0, 24'($urandom), rc);
  endtask

  // Pixel j of a line leaves on the strobe after it; the DE-low strobe flushes the last one.
  task automatic send_line(input int ncols, input int r, input bit s, input int abort_at, input bit fixed);
    int rc, prev_y, y;
    logic [23:0] d;
    prev_y = 0;
    for (int j = 0; j < ncols; j++) begin
      if (fixed) begin
        d = pat_rgb[pat_idx]; y = pat_y[pat_idx]; pat_idx = (pat_idx + 1) % 5;
      end else begin
        d = 24'($urandom); y = luma_ref(d);
      end
      if (j == abort_at) begin
        tick(1'b1, 1'b1, d, rc);
        push_ev(K_ERR, rc);
        return;
      end
      tick(1'b0, 1'b1, d, rc);
      if (j > 0) push_pix(rc, prev_y, j - 1, r, s && (j == 1), 1'b0);
      prev_y = y;
    end
    tick(1'b0, 1'b0, 24'($urandom), rc);
    push_pix(rc, prev_y, ncols - 1, r, s && (ncols == 1), 1'b1);
  endtask

  task automatic end_frame();
    int rc;
    tick(1'b1, 1'b0, 24'($urandom), rc);
    push_ev(K_EOF, rc);
    blank();
  endtask

  task automatic send_frame(input int nrows, input int ncols, input bit fixed);
    for (int r = 0; r < nrows; r++) begin
      send_line(ncols, r, r == 0, -1, fixed);
      blank();
    end
    end_frame();
  endtask

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge core_clk); k++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  always @(negedge core_clk) begin
    int kind;
    exp_t e;
    if (rst_n === 1'b1 && (valid || eof || err)) begin
      kind = valid ? K_PIX : (eof ? K_EOF : K_ERR);
      if (valid) n_valid++;
      if (eof)   n_eof++;
      if (err)   n_errp++;
      if (q.size() == 0) begin
        chk("unexpected_output_kind", kind + 1, 0);
      end else begin
        e = q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (e.kind == K_PIX) begin
          chk("gray", gray, e.gray);
          chk("col", col, e.col);
          chk("row", row, e.row);
          chk("sof", sof, e.sof);
          chk("eol", eol, e.eol);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded its cycle budget at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, e0, r0, rc;
    logic [23:0] a, b, c;
    rst_n = 1'b0; pclk = 1'b0; vsync = 1'b0; hsync = 1'b0; de = 1'b0; pix = '0;

    // Reset held while inputs toggle
    for (int i = 0; i < 12; i++) begin
      @(posedge core_clk); #1;
      pclk = 1'($urandom); vsync = 1'($urandom); hsync = 1'($urandom);
      de = 1'($urandom); pix = 24'($urandom);
      @(negedge core_clk);
      chk("reset_outputs", out_all, 0);
    end
    @(posedge core_clk); #1;
    pclk = 1'b0; vsync = 1'b0; hsync = 1'b0; de = 1'b0; pix = '0;
    #2 rst_n = 1'b1;

    // DE activity before any VSYNC must be ignored
    repeat (4) tick(1'b0, 1'b1, 24'($urandom), rc);
    blank();
    chk("prelock_locked", locked, 0);
    chk("prelock_valid_cnt", n_valid, 0);
    tick(1'b1, 1'b0, 24'($urandom), rc);
    blank();
    chk("locked_after_vsync", locked, 1);

    // 4x3 frame with the reference colour table
    n0 = n_valid; e0 = n_eof;
    send_frame(3, 4, 1'b1);
    wait_drain();
    chk("frame_valid_cnt", n_valid - n0, 12);
    chk("frame_eof_cnt", n_eof - e0, 1);

    // VSYNC rise on the 3rd pixel: ERR, held pixel lost, no EOF, next line is row 0 with SOF
    e0 = n_eof; r0 = n_errp;
    send_line(5, 0, 1'b1, 2, 1'b0);
    wait_drain();
    chk("abort_err_cnt", n_errp - r0, 1);
    chk("abort_no_eof", n_eof - e0, 0);
    blank();
    send_line(3, 0, 1'b1, -1, 1'b0);
    blank();
    end_frame();
    wait_drain();

    // Random frame geometries
    for (int f = 0; f < 3; f++) begin
      send_frame($urandom_range(1, 3), $urandom_range(1, 6), 1'b0);
      wait_drain();
    end

    // Over-long line: column saturates at all-ones
    send_line(CMAX + 3, 0, 1'b1, -1, 1'b0);
    blank();
    end_frame();
    wait_drain();

    // Async reset while a pixel is on the output
    a = 24'($urandom); b = 24'($urandom); c = 24'($urandom);
    tick(1'b0, 1'b1, a, rc);
    tick(1'b0, 1'b1, b, rc);
    push_pix(rc, luma_ref(a), 0, 0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, c, rc);
    push_pix(rc, luma_ref(b), 1, 0, 1'b0, 1'b0);
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    chk("pre_arst_valid", valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_outputs", out_all, 0);
    repeat (3) @(posedge core_clk);
    #2 vsync = 1'b0; de = 1'b0; rst_n = 1'b1;
    n0 = n_valid;
    repeat (4) tick(1'b0, 1'b1, 24'($urandom), rc);
    blank();
    chk("post_rst_locked", locked, 0);
    chk("post_rst_valid_cnt", n_valid - n0, 0);
    tick(1'b1, 1'b0, 24'($urandom), rc);
    blank();
    chk("post_rst_relock", locked, 1);
    send_frame(2, 2, 1'b0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
